// File: rtl/cva6_obi_mux.sv
// ============================================================================
//  Module   : cva6_obi_mux
//  Purpose  : N-to-1 OBI manager multiplexer with round-robin arbitration,
//             grant locking, outstanding tracking and in-order response routing.
//             Optional macro CVA6_OBI_MUX_RSP_REG_EN registers the response path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cva6_obi_mux #(
  parameter int unsigned NumPorts       = 6,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumPorts-1:0]               mgr_req_i,
  output logic [NumPorts-1:0]               mgr_gnt_o,
  input  logic [NumPorts*AddrWidth-1:0]     mgr_addr_i,
  input  logic [NumPorts-1:0]               mgr_we_i,
  input  logic [NumPorts*(DataWidth/8)-1:0] mgr_be_i,
  input  logic [NumPorts*DataWidth-1:0]     mgr_wdata_i,
  output logic [NumPorts-1:0]               mgr_rvalid_o,
  output logic [DataWidth-1:0]              mgr_rdata_o,
  output logic                              mgr_err_o,
  output logic                              sbr_req_o,
  input  logic                              sbr_gnt_i,
  output logic [AddrWidth-1:0]              sbr_addr_o,
  output logic                              sbr_we_o,
  output logic [DataWidth/8-1:0]            sbr_be_o,
  output logic [DataWidth-1:0]              sbr_wdata_o,
  input  logic                              sbr_rvalid_i,
  input  logic [DataWidth-1:0]              sbr_rdata_i,
  input  logic                              sbr_err_i,
  output logic                              protocol_err_o
);

  localparam int unsigned c_IDX_W = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned c_PTR_W = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned c_CNT_W = $clog2(MaxOutstanding) + 1;
  localparam int unsigned c_BE_W  = DataWidth / 8;
  localparam logic [NumPorts-1:0] c_ONE = {{(NumPorts-1){1'b0}}, 1'b1};

  logic [c_IDX_W-1:0] r_rr;
  logic               r_lock_vld;
  logic [c_IDX_W-1:0] r_lock_idx;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_IDX_W-1:0] r_fifo [MaxOutstanding];
  logic               r_perr;

  logic               w_arb_vld;
  logic [c_IDX_W-1:0] w_arb_idx;
  logic [c_IDX_W-1:0] w_cand;
  logic               w_lock_hold;
  logic               w_lock_drop;
  logic               w_win_vld;
  logic [c_IDX_W-1:0] w_win_idx;
  logic               w_full;
  logic               w_hs;
  logic               w_pop;
  logic               w_unsol;
  logic [c_IDX_W-1:0] w_head;
  logic [NumPorts-1:0] w_rsp_oh;

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(MaxOutstanding - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Scan from the lowest offset last so the port closest to r_rr wins.
  always_comb begin
    w_arb_vld = 1'b0;
    w_arb_idx = '0;
    w_cand    = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      w_cand = c_IDX_W'((int'(r_rr) + i) % NumPorts);
      if (mgr_req_i[w_cand]) begin
        w_arb_vld = 1'b1;
        w_arb_idx = w_cand;
      end
    end
  end

  assign w_lock_hold = r_lock_vld &  mgr_req_i[r_lock_idx];
  assign w_lock_drop = r_lock_vld & ~mgr_req_i[r_lock_idx];
  assign w_win_vld   = w_lock_hold | w_arb_vld;
  assign w_win_idx   = w_lock_hold ? r_lock_idx : w_arb_idx;

  // A response in the same cycle frees a slot, so a full tracker still accepts.
  assign w_full    = (r_cnt == c_CNT_W'(MaxOutstanding));
  assign sbr_req_o = w_win_vld & ~(w_full & ~sbr_rvalid_i) & ~rst_i;
  assign w_hs      = sbr_req_o & sbr_gnt_i;
  assign mgr_gnt_o = w_hs ? (c_ONE << w_win_idx) : '0;

  assign sbr_addr_o  = mgr_addr_i[w_win_idx*AddrWidth +: AddrWidth];
  assign sbr_we_o    = mgr_we_i[w_win_idx];
  assign sbr_be_o    = mgr_be_i[w_win_idx*c_BE_W +: c_BE_W];
  assign sbr_wdata_o = mgr_wdata_i[w_win_idx*DataWidth +: DataWidth];

  assign w_pop    = sbr_rvalid_i & (r_cnt != '0) & ~rst_i;
  assign w_unsol  = sbr_rvalid_i & (r_cnt == '0);
  assign w_head   = r_fifo[r_rptr];
  assign w_rsp_oh = w_pop ? (c_ONE << w_head) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_perr     <= 1'b0;
    end else begin
      if (w_hs) begin
        r_lock_vld <= 1'b0;
        r_rr       <= (w_win_idx == c_IDX_W'(NumPorts - 1)) ? '0 : w_win_idx + c_IDX_W'(1);
      end else if (sbr_req_o) begin
        r_lock_vld <= 1'b1;
        r_lock_idx <= w_win_idx;
      end else if (w_lock_drop) begin
        r_lock_vld <= 1'b0;
      end
      if (w_lock_drop | w_unsol) begin
        r_perr <= 1'b1;
      end
      if (w_hs) begin
        r_wptr <= f_ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_ptr_inc(r_rptr);
      end
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Tracker storage needs no reset: only entries below r_cnt are ever read.
  always_ff @(posedge clk_i) begin
    if (w_hs) begin
      r_fifo[r_wptr] <= w_win_idx;
    end
  end

  assign protocol_err_o = r_perr;

`ifdef CVA6_OBI_MUX_RSP_REG_EN
  logic [NumPorts-1:0]  r_rsp_vld;
  logic [DataWidth-1:0] r_rsp_data;
  logic                 r_rsp_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_rsp_vld  <= w_rsp_oh;
      r_rsp_data <= sbr_rdata_i;
      r_rsp_err  <= sbr_err_i;
    end
  end

  assign mgr_rvalid_o = r_rsp_vld;
  assign mgr_rdata_o  = r_rsp_data;
  assign mgr_err_o    = r_rsp_err;
`else
  assign mgr_rvalid_o = w_rsp_oh;
  assign mgr_rdata_o  = sbr_rdata_i;
  assign mgr_err_o    = sbr_err_i;
`endif

endmodule

`default_nettype wire
